// File: rtl/fetch_npc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_npc_ctrl_if
// Description : Bundle of the fetch controller's PC, instruction-memory,
//               decode and redirect signals.
//               slave  modport : seen by fetch_npc_ctrl
//               master modport : seen by the PC register / memory / decode
//               Signals:
//                 Address       PC register output (current PC)
//                 R             next PC into the PC register
//                 Imem_Req/Addr fetch request and aligned address
//                 Imem_Ack/Data memory response
//                 Instr/Instr_Valid/Instr_Ready  decode handshake
//                 Jump/Jump_Target, Branch_Taken/Branch_Target  redirects
//                 Fetch_Err     sticky error flag
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_npc_ctrl_if;
  logic [31:0] Address;
  logic [31:0] R;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Fetch_Err;

  modport slave (
    input  Address, Imem_Ack, Imem_Data, Instr_Ready,
           Jump, Jump_Target, Branch_Taken, Branch_Target,
    output R, Imem_Req, Imem_Addr, Instr, Instr_Valid, Fetch_Err
  );

  modport master (
    output Address, Imem_Ack, Imem_Data, Instr_Ready,
           Jump, Jump_Target, Branch_Taken, Branch_Target,
    input  R, Imem_Req, Imem_Addr, Instr, Instr_Valid, Fetch_Err
  );
endinterface
`default_nettype wire

// File: rtl/fetch_npc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_npc_ctrl
// Description : Next-PC and instruction-fetch controller. Drives R into a PC
//               register that loads every cycle, fetches the word at the PC
//               over a req/ack handshake, holds it for decode over
//               valid/ready, then selects sequential, branch or jump next PC.
//               Stalls are done by feeding Address back as R.
//               Ports: Clk, Reset (sync, active-high), bus (slave modport of
//               fetch_npc_ctrl_if carrying all PC/memory/decode signals).
//               Optional macro FETCH_ALIGN_CHECK_EN: a misaligned PC in FETCH
//               issues no request and goes to the error state.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_npc_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  fetch_npc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc;
  logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (bus.Address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    npc        = bus.Address;
    wait_cnt_d = 8'd0;
    instr_d    = instr_q;
    req_d      = 1'b0;

    case (state_q)
      IDLE: begin
        npc     = RESET_ADDR;
        state_d = FETCH;
      end
      FETCH: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (misaligned) begin
          state_d = ERR;
        end else if (bus.Imem_Ack) begin
          // Ack wins over a timeout in the same cycle.
          instr_d = bus.Imem_Data;
          state_d = HOLD;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          state_d = ERR;
        end
      end
      HOLD: begin
        if (bus.Instr_Ready) begin
          if (bus.Jump)              npc = bus.Jump_Target;
          else if (bus.Branch_Taken) npc = bus.Branch_Target;
          else                       npc = bus.Address + 32'd4;
          state_d = FETCH;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (Reset) begin
      state_d    = IDLE;
      npc        = RESET_ADDR;
      wait_cnt_d = 8'd0;
      instr_d    = 32'd0;
    end

    // The PC loads npc at this edge, so npc is the Address seen in the next
    // FETCH cycle; the request is decided from it up front.
`ifdef FETCH_ALIGN_CHECK_EN
    req_d = (state_d == FETCH) && (npc[1:0] == 2'b00);
`else
    req_d = (state_d == FETCH);
`endif
  end

  assign valid_d = (state_d == HOLD);
  assign err_d   = (state_d == ERR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      instr_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      instr_q    <= instr_d;
    end
  end

  assign bus.R           = npc;
  assign bus.Imem_Req    = req_q;
  assign bus.Imem_Addr   = {bus.Address[31:2], 2'b00};
  assign bus.Instr       = instr_q;
  assign bus.Instr_Valid = valid_q;
  assign bus.Fetch_Err   = err_q;

endmodule
`default_nettype wire

// File: doc/fetch_npc_ctrl.md
Name: fetch_npc_ctrl

Overview:
- Drives the next-address input R of the PC register, which loads R on every clock edge with no enable.
- Consumes the PC's Address output and issues an instruction fetch to instruction memory over a req/ack handshake.
- Holds the fetched word for decode over a valid/ready handshake, then computes the next PC: sequential, branch or jump.
- Stalls the PC by feeding Address back as R.

Parameters:
RESET_ADDR, 32'h00000000, address loaded into PC in the cycle after reset.
MAX_WAIT, 15, FETCH cycles without Imem_Ack tolerated before timeout; legal 1..255.

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Address  input  32  current PC value from the PC register
R  output  32  next PC value to the PC register (combinational from state, Address, redirect inputs)
Imem_Req  output  1  fetch request, registered
Imem_Addr  output  32  fetch address, valid while Imem_Req=1
Imem_Ack  input  1  memory has returned data; meaningful only while Imem_Req=1
Imem_Data  input  32  instruction word, sampled when Imem_Ack=1
Instr  output  32  held instruction, registered
Instr_Valid  output  1  Instr is valid for decode
Instr_Ready  input  1  decode accepts Instr this cycle
Jump  input  1  unconditional redirect, sampled only on accept
Jump_Target  input  32  jump destination
Branch_Taken  input  1  taken-branch redirect, sampled only on accept
Branch_Target  input  32  branch destination
Fetch_Err  output  1  sticky error flag, registered

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset (any state, any cycle):
  - Next state IDLE.
  - Imem_Req=0, Instr_Valid=0, Instr=0, Fetch_Err=0, wait counter=0.
  - While Reset=1, R=RESET_ADDR.
  - A pending Imem_Ack during reset is discarded.
- FSM states: IDLE, FETCH, HOLD, ERR.
- IDLE:
  - Lasts exactly one cycle. R=RESET_ADDR, Imem_Req=0. Next state FETCH.
- FETCH:
  - Imem_Req=1 and Imem_Addr={Address[31:2],2'b00}. Both are held stable until ack.
  - R=Address (PC stalled).
  - Wait counter (8 bit) is cleared on entry and increments each FETCH cycle without Imem_Ack.
  - Imem_Ack=1: Instr<=Imem_Data, Instr_Valid<=1, Imem_Req<=0, next HOLD. Data is visible at decode the cycle after ack.
  - Imem_Ack=0 while counter==MAX_WAIT: next ERR. Ack is therefore accepted in any of the first MAX_WAIT+1 FETCH cycles.
  - If Imem_Ack=1 in the same cycle as counter==MAX_WAIT, ack wins.
- HOLD:
  - Instr_Valid=1 and Instr stable.
  - While Instr_Ready=0: R=Address and state is held.
  - On Instr_Ready=1 (accept):
    - R=Jump_Target if Jump=1; else Branch_Target if Branch_Taken=1; else Address+4. Jump has priority over branch.
    - Address+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
    - Instr_Valid<=0, next FETCH. The new Address is visible in FETCH.
  - Jump and Branch_Taken are ignored in every other cycle and state.
- ERR:
  - Imem_Req=0, Instr_Valid=0, R=Address, Fetch_Err=1.
  - Leaves only on Reset.
- Stray input: Imem_Ack in IDLE, HOLD or ERR is ignored.
- Redirect targets are passed to R unmodified; low bits are not masked.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: in FETCH, if Address[1:0]!=2'b00, no request is issued (Imem_Req stays 0). Next state is ERR, with Fetch_Err=1 the following cycle.
- Undefined: no check; Imem_Addr low two bits are forced to 00 and fetch proceeds normally.

Test Plan:
- Reset 2 cycles, RESET_ADDR=32'h100, memory acks 1 cycle after req with 32'hDEADBEEF:
  - Imem_Addr=32'h100.
  - Instr=32'hDEADBEEF with Instr_Valid=1.
  - Instr_Ready=1 -> next Imem_Addr=32'h104.
- HOLD with Instr_Ready low 5 cycles: R=Address every cycle, Instr unchanged. Then Ready with Jump=1, Jump_Target=32'h2000, Branch_Taken=1, Branch_Target=32'h3000 -> next Imem_Addr=32'h2000.
- Address=32'hFFFFFFFC, accept without redirect -> next Address=32'h00000000.
- MAX_WAIT=15, Imem_Ack never asserted:
  - Imem_Req high for 16 cycles, then Fetch_Err=1 and Imem_Req=0.
  - A later Imem_Ack is ignored.
  - Reset clears Fetch_Err.
- Ack on the 16th FETCH cycle (counter==MAX_WAIT) -> HOLD, Fetch_Err stays 0. Reset asserted during a FETCH wait -> Imem_Req=0 next cycle, IDLE, then FETCH at RESET_ADDR.
- With FETCH_ALIGN_CHECK_EN, Jump_Target=32'h2002 -> no Imem_Req, Fetch_Err=1. Without the macro -> Imem_Addr=32'h2000.
